// File: rtl/fetcher_if.sv
// Fetch-side bus bundle: flush/redirect, memory request/response and issue handshake.
// The master modport is the fetcher's view of the bus, and the slave modport is its environment's view.
interface fetcher_if;
  logic        has_misbranch;
  logic [31:0] correct_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_inst;
  logic        issue_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        can_issue;
  logic        out_has_jump;

  modport master (
    input  has_misbranch, correct_pc, mem_done, mem_inst, issue_ready,
    output mem_req, mem_addr, inst, pc, can_issue, out_has_jump
  );

  modport slave (
    output has_misbranch, correct_pc, mem_done, mem_inst, issue_ready,
    input  mem_req, mem_addr, inst, pc, can_issue, out_has_jump
  );
endinterface

// File: rtl/fetcher.sv
// Instruction fetcher: IDLE/WAIT/DROP fetch FSM feeding a 4-entry queue toward issue.
// Define FETCH_BTFN_PREDICT_EN to predict backward B-type branches taken.
module fetcher (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  fetcher_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Returns {jump, next_pc} for a word fetched at fpc.
  function automatic logic [32:0] predict(input logic [31:0] w, input logic [31:0] fpc);
    logic [31:0] j_imm;
    logic [32:0] res;
    j_imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    res   = {1'b0, fpc + 32'd4};
    if (w[6:0] == 7'b1101111) begin
      res = {1'b1, fpc + j_imm};
    end else if (w[6:0] == 7'b1100011) begin
`ifdef FETCH_BTFN_PREDICT_EN
      if (w[31]) begin
        res = {1'b1, fpc + {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0}};
      end else begin
        res = {1'b0, fpc + 32'd4};
      end
`else
      res = {1'b0, fpc + 32'd4};
`endif
    end else begin
      res = {1'b0, fpc + 32'd4};
    end
    return res;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  head_q, head_d;
  logic [1:0]  tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic [64:0] queue_q [4];
  logic [64:0] queue_d [4];
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        can_issue_q, can_issue_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        jump_q, jump_d;
  logic        push_s, pop_s;
  logic [32:0] pred_s;

  assign push_s = (state_q == ST_WAIT) && bus.mem_done;
  assign pop_s  = (count_q != 3'd0) && bus.issue_ready;
  assign pred_s = predict(bus.mem_inst, fetch_pc_q);

  // Next-state logic for the FSM, queue and issue outputs.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    queue_d     = queue_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    can_issue_d = can_issue_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    jump_d      = jump_q;
    if (!rdy) begin
      state_d = state_q;
    end else if (bus.has_misbranch) begin
      // Flush: an outstanding request must still be drained before refetching.
      head_d      = 2'd0;
      tail_d      = 2'd0;
      count_d     = 3'd0;
      can_issue_d = 1'b0;
      fetch_pc_d  = bus.correct_pc;
      if ((state_q == ST_WAIT || state_q == ST_DROP) && !bus.mem_done) begin
        state_d = ST_DROP;
      end else begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    end else begin
      can_issue_d = 1'b0;
      if (pop_s) begin
        {inst_d, pc_d, jump_d} = queue_q[head_q];
        head_d      = head_q + 2'd1;
        can_issue_d = 1'b1;
      end else begin
        head_d = head_q;
      end
      if (push_s) begin
        queue_d[tail_q] = {bus.mem_inst, fetch_pc_q, pred_s[32]};
        tail_d          = tail_q + 2'd1;
      end else begin
        tail_d = tail_q;
      end
      count_d = count_q + {2'b00, push_s} - {2'b00, pop_s};
      case (state_q)
        ST_IDLE: begin
          if (count_q < 3'd4) begin
            state_d    = ST_WAIT;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.mem_done) begin
            fetch_pc_d = pred_s[31:0];
            state_d    = ST_IDLE;
            mem_req_d  = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DROP: begin
          if (bus.mem_done) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= 32'd0;
      head_q      <= 2'd0;
      tail_q      <= 2'd0;
      count_q     <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        queue_q[i] <= 65'd0;
      end
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      can_issue_q <= 1'b0;
      inst_q      <= 32'd0;
      pc_q        <= 32'd0;
      jump_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      queue_q     <= queue_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      can_issue_q <= can_issue_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      jump_q      <= jump_d;
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.can_issue    = can_issue_q;
  assign bus.inst         = inst_q;
  assign bus.pc           = pc_q;
  assign bus.out_has_jump = jump_q;

endmodule

// File: tb/tb_fetcher.sv
// Directed self-checking bench for fetcher; expected values are hand-computed.
module tb_fetcher;
  logic clk;
  logic rst;
  logic rdy;
  int   n_checks;
  int   n_fail;

  fetcher_if bus ();

  fetcher dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_done = 1'b0;
    bus.has_misbranch = 1'b0;
    bus.issue_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic respond(input logic [31:0] w);
    bus.mem_done = 1'b1;
    bus.mem_inst = w;
    tick();
    bus.mem_done = 1'b0;
    bus.mem_inst = 32'h0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
    check({tag, "_addr"}, bus.mem_addr, addr);
  endtask

  logic [31:0] exp_next;
  logic        exp_jump;

  initial begin
    n_checks = 0;
    n_fail = 0;
    rdy = 1'b1;
    bus.correct_pc = 32'h0;
    bus.mem_inst = 32'h0;
    do_reset();

    // Reset state and single-word fetch/issue
    check("rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_ci", {31'd0, bus.can_issue}, 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_pc", bus.pc, 32'd0);
    check("rst_jmp", {31'd0, bus.out_has_jump}, 32'd0);
    bus.issue_ready = 1'b1;
    tick();
    check("f0_req", {31'd0, bus.mem_req}, 32'd1);
    check("f0_addr", bus.mem_addr, 32'h0);
    respond(32'h00000013);
    check("nobypass_ci", {31'd0, bus.can_issue}, 32'd0);
    check("done_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    check("iss0_ci", {31'd0, bus.can_issue}, 32'd1);
    check("iss0_pc", bus.pc, 32'h0);
    check("iss0_inst", bus.inst, 32'h00000013);
    check("iss0_jmp", {31'd0, bus.out_has_jump}, 32'd0);
    check("f1_addr", bus.mem_addr, 32'h4);
    tick();
    check("iss0_once", {31'd0, bus.can_issue}, 32'd0);

    // Queue fills to four, stray fifth done ignored
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      wait_req("fill", 32'(4 * i));
      respond(32'h00000013 | (32'(i) << 20));
      tick();
    end
    check("full_req", {31'd0, bus.mem_req}, 32'd0);
    respond(32'h00500013);
    tick();
    check("full_req2", {31'd0, bus.mem_req}, 32'd0);
    check("full_ci", {31'd0, bus.can_issue}, 32'd0);
    bus.issue_ready = 1'b1;
    tick();
    check("pop_ci", {31'd0, bus.can_issue}, 32'd1);
    check("pop_pc", bus.pc, 32'h0);
    bus.issue_ready = 1'b0;
    tick();
    check("resume_req", {31'd0, bus.mem_req}, 32'd1);
    check("resume_addr", bus.mem_addr, 32'h10);
    bus.issue_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("drain_pc", bus.pc, 32'(4 * i));
      check("drain_inst", bus.inst, 32'h00000013 | (32'(i) << 20));
    end
    tick();
    check("drain_empty", {31'd0, bus.can_issue}, 32'd0);

    // JAL at 0x8
    do_reset();
    bus.issue_ready = 1'b1;
    tick();
    respond(32'h00000013);
    tick();
    respond(32'h00000013);
    tick();
    check("jal_fetch", bus.mem_addr, 32'h8);
    respond(32'h1000006F);
    tick();
    check("jal_ci", {31'd0, bus.can_issue}, 32'd1);
    check("jal_pc", bus.pc, 32'h8);
    check("jal_jmp", {31'd0, bus.out_has_jump}, 32'd1);
    check("jal_next", bus.mem_addr, 32'h108);

    // Misbranch while waiting on 0x14 with one word queued
    do_reset();
    bus.issue_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      respond(32'h00000013);
      tick();
    end
    bus.issue_ready = 1'b0;
    respond(32'h00000013);
    tick();
    check("mb_wait_addr", bus.mem_addr, 32'h14);
    bus.has_misbranch = 1'b1;
    bus.correct_pc = 32'h200;
    bus.issue_ready = 1'b1;
    tick();
    bus.has_misbranch = 1'b0;
    check("mb_ci", {31'd0, bus.can_issue}, 32'd0);
    check("mb_drop_req", {31'd0, bus.mem_req}, 32'd1);
    tick();
    check("mb_flushed", {31'd0, bus.can_issue}, 32'd0);
    respond(32'h1000006F);
    check("drop_done_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    check("mb_discard_ci", {31'd0, bus.can_issue}, 32'd0);
    check("mb_next_addr", bus.mem_addr, 32'h200);

    // Backward BEQ at 0x40
`ifdef FETCH_BTFN_PREDICT_EN
    exp_next = 32'h3C;
    exp_jump = 1'b1;
`else
    exp_next = 32'h44;
    exp_jump = 1'b0;
`endif
    do_reset();
    bus.issue_ready = 1'b1;
    bus.has_misbranch = 1'b1;
    bus.correct_pc = 32'h40;
    tick();
    bus.has_misbranch = 1'b0;
    check("redir_idle_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    check("beq_fetch", bus.mem_addr, 32'h40);
    respond(32'hFE000EE3);
    tick();
    check("beq_pc", bus.pc, 32'h40);
    check("beq_jmp", {31'd0, bus.out_has_jump}, {31'd0, exp_jump});
    check("beq_next", bus.mem_addr, exp_next);
    tick();

    // rdy low for three cycles with a done in the middle
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mem_done = (i == 1);
      bus.mem_inst = 32'h00000013;
      tick();
      check("frz_req", {31'd0, bus.mem_req}, 32'd1);
      check("frz_addr", bus.mem_addr, exp_next);
      check("frz_ci", {31'd0, bus.can_issue}, 32'd0);
      check("frz_pc", bus.pc, 32'h40);
    end
    bus.mem_done = 1'b0;
    rdy = 1'b1;
    tick();
    check("frz_nopush", {31'd0, bus.can_issue}, 32'd0);
    respond(32'h00000013);
    tick();
    check("thaw_ci", {31'd0, bus.can_issue}, 32'd1);
    check("thaw_pc", bus.pc, exp_next);

    // Async reset mid-WAIT, then a stray done is ignored
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", {31'd0, bus.mem_req}, 32'd0);
    check("arst_pc", bus.pc, 32'd0);
    tick();
    rst = 1'b0;
    bus.mem_done = 1'b1;
    bus.mem_inst = 32'h00000013;
    tick();
    bus.mem_done = 1'b0;
    check("stray_addr", bus.mem_addr, 32'h0);
    tick();
    check("stray_ci", {31'd0, bus.can_issue}, 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
